// File: rtl/mem_arbiter.sv
// Purpose: share one single-port synchronous RAM between the CPU core (m0) and the UART loader (m1).
// Latency: the grant is combinational in the request cycle, and read data returns one cycle after the grant.
// Backpressure: a master holds req/we/addr/wdata until it sees its gnt; m1 bursts yield one slot after MAX_BURST.
module mem_arbiter #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   // master 0: CPU core
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   // master 1: UART program loader
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic              m1_lock,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   // RAM side
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

   // Index of the master granted most recently (1 = m1). It resets to 1 so m0 wins the first contention.
   logic             last;
   // Count of consecutive locked m1 grants. It saturates so the yield happens only when m0 actually asks.
   logic [CNT_W-1:0] burst_cnt;
   logic             sel0;
   logic             sel1;
   logic             burst_ok;

   assign burst_ok = m1_lock && last && (burst_cnt < BURST_MAX);

   // Grant selection: a lone requester wins; on contention an open m1 burst keeps the slot, else round-robin.
   always_comb begin
      sel0 = 1'b0;
      sel1 = 1'b0;
      if (m0_req && !m1_req) begin
         sel0 = 1'b1;
      end else if (m1_req && !m0_req) begin
         sel1 = 1'b1;
      end else if (m0_req && m1_req) begin
         if (burst_ok) begin
            sel1 = 1'b1;
         end else if (last) begin
            sel0 = 1'b1;
         end else begin
            sel1 = 1'b1;
         end
      end
   end

   // Reset gates the grants directly, so no access (in particular no write) can leak out while held in reset.
   assign m0_gnt = sel0 & rst_n;
   assign m1_gnt = sel1 & rst_n;

   // RAM port mux. With no grant, the address and data idle on the m0 values and the write enable stays low.
   always_comb begin
      ram_addr = m0_addr;
      ram_data = m0_wdata;
      if (m1_gnt) begin
         ram_addr = m1_addr;
         ram_data = m1_wdata;
      end
   end

   assign ram_wren = (m0_gnt & m0_we) | (m1_gnt & m1_we);

   // The RAM registers its output, so read data is simply ram_q in the cycle after the grant.
   assign m0_rdata = ram_q;
   assign m1_rdata = ram_q;

   // Arbitration history: remember the winner, and count locked m1 grants (any other grant restarts the count).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last      <= 1'b1;
         burst_cnt <= '0;
      end else if (m0_gnt) begin
         last      <= 1'b0;
         burst_cnt <= '0;
      end else if (m1_gnt) begin
         last <= 1'b1;
         if (!m1_lock) begin
            burst_cnt <= '0;
         end else if (burst_cnt != BURST_MAX) begin
            burst_cnt <= burst_cnt + 1'b1;
         end
      end
   end

   // Read-return flags: high exactly one cycle after a read grant. Writes complete at the grant edge silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
      end else begin
         m0_rvalid <= m0_gnt & ~m0_we;
         m1_rvalid <= m1_gnt & ~m1_we;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter, with a behavioural synchronous RAM attached to the RAM port.
// Expected read data is queued per master when a read grant is expected, and it is checked on the next cycle.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_we, m0_gnt, m0_rvalid;
   logic [7:0]  m0_addr;
   logic [31:0] m0_wdata, m0_rdata;
   logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_lock;
   logic [7:0]  m1_addr;
   logic [31:0] m1_wdata, m1_rdata;
   logic [7:0]  ram_addr;
   logic [31:0] ram_data, ram_q;
   logic        ram_wren;

   logic [31:0] ram  [256];
   logic [31:0] gold [256];
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
   );

   // Single-port synchronous RAM, registered output
   always @(posedge clk) begin
      if (ram_wren) ram[ram_addr] <= ram_data;
      ram_q <= ram[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check outputs at the negedge against the expected grants, then update the scoreboard.
   task automatic step(input logic e0, input logic e1);
      logic ev0, ev1;
      @(negedge clk);
      ev0 = (q0.size() > 0);
      ev1 = (q1.size() > 0);
      chk("m0_rvalid", 32'(m0_rvalid), 32'(ev0));
      if (ev0) chk("m0_rdata", m0_rdata, q0.pop_front());
      chk("m1_rvalid", 32'(m1_rvalid), 32'(ev1));
      if (ev1) chk("m1_rdata", m1_rdata, q1.pop_front());
      chk("m0_gnt", 32'(m0_gnt), 32'(e0));
      chk("m1_gnt", 32'(m1_gnt), 32'(e1));
      chk("ram_wren", 32'(ram_wren), 32'((e0 & m0_we) | (e1 & m1_we)));
      chk("ram_addr", 32'(ram_addr), e1 ? 32'(m1_addr) : 32'(m0_addr));
      chk("ram_data", ram_data, e1 ? m1_wdata : m0_wdata);
      if (e0 && !m0_we) q0.push_back(gold[m0_addr]);
      if (e0 &&  m0_we) gold[m0_addr] = m0_wdata;
      if (e1 && !m1_we) q1.push_back(gold[m1_addr]);
      if (e1 &&  m1_we) gold[m1_addr] = m1_wdata;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i]  <= 32'h1000_0000 + 32'(i * 3);
         gold[i]  = 32'h1000_0000 + 32'(i * 3);
      end
      ram[5]  <= 32'h1234_5678;
      gold[5]  = 32'h1234_5678;

      // Reset state: requests are present, but nothing may be granted or written
      rst_n = 1'b0;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h00; m0_wdata = 32'h0;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h00; m1_wdata = 32'h0; m1_lock = 1'b0;
      @(negedge clk);
      chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
      chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
      chk("rst_ram_wren", 32'(ram_wren), 32'd0);
      chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
      chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
      m0_req = 1'b0; m0_we = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // m0 reads address 0x05
      m0_addr = 8'h05; m0_req = 1'b1;
      step(1'b1, 1'b0);
      m0_req = 1'b0;
      step(1'b0, 1'b0);

      // m1 writes 0x10, reads it back on the next cycle; m0 is idle
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h10; m1_wdata = 32'hDEAD_BEEF;
      step(1'b0, 1'b1);
      m1_we = 1'b0;
      step(1'b0, 1'b1);
      m1_req = 1'b0;
      step(1'b0, 1'b0);

      // Both masters read continuously with no lock: the grants strictly alternate, starting with m0
      m0_addr = 8'h30; m1_addr = 8'h40; m0_req = 1'b1; m1_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(i % 2 == 0, i % 2 == 1);
         if (i % 2 == 0) m0_addr++; else m1_addr++;
      end
      m0_req = 1'b0; m1_req = 1'b0;
      step(1'b0, 1'b0);

      // Locked m1 burst writes 0x00..0x07 while m0 keeps requesting: expect 4 x m1, 1 x m0, then 4 x m1
      m1_lock = 1'b1; m1_we = 1'b1; m1_addr = 8'h00; m1_wdata = 32'hC0DE_0000; m1_req = 1'b1;
      m0_addr = 8'h50; m0_we = 1'b0; m0_req = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step(i == 4, i != 4);
         if (i != 4) begin
            m1_addr++;
            m1_wdata = {24'hC0DE_00, m1_addr};
         end
      end
      m1_req = 1'b0; m1_lock = 1'b0;
      step(1'b1, 1'b0);
      m0_req = 1'b0;
      m1_we = 1'b0; m1_addr = 8'h07; m1_req = 1'b1;
      step(1'b0, 1'b1);
      m1_req = 1'b0;
      step(1'b0, 1'b0);

      // Locked m1 with m0 idle: the counter saturates, and m0 gets the slot as soon as it asks
      m1_lock = 1'b1; m1_addr = 8'h60; m1_req = 1'b1;
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1);
      m0_addr = 8'h05; m0_req = 1'b1;
      step(1'b1, 1'b0);
      m0_req = 1'b0;
      step(1'b0, 1'b1);

      // The lock is released mid-burst, so the next contention falls back to round-robin
      m0_req = 1'b1;
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      m1_lock = 1'b0;
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      m0_req = 1'b0; m1_req = 1'b0;
      step(1'b0, 1'b0);

      // m0 writes 0xA5A5A5A5 to 0x20 (this returns no rvalid), then reads it back
      m0_addr = 8'h20; m0_wdata = 32'hA5A5_A5A5; m0_we = 1'b1; m0_req = 1'b1;
      step(1'b1, 1'b0);
      m0_we = 1'b0;
      step(1'b1, 1'b0);
      m0_req = 1'b0;
      step(1'b0, 1'b0);

      // Reset is asserted in the cycle after an m0 read grant
      m0_addr = 8'h05; m0_req = 1'b1;
      step(1'b1, 1'b0);
      m0_we = 1'b1; m1_req = 1'b1; m1_we = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("rstmid_m0_rvalid", 32'(m0_rvalid), 32'd0);
      chk("rstmid_m0_gnt", 32'(m0_gnt), 32'd0);
      chk("rstmid_m1_gnt", 32'(m1_gnt), 32'd0);
      chk("rstmid_ram_wren", 32'(ram_wren), 32'd0);
      q0.delete();
      @(posedge clk); #1;
      rst_n = 1'b1; m0_we = 1'b0; m1_we = 1'b0; m1_addr = 8'h10;
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      m0_req = 1'b0; m1_req = 1'b0;
      step(1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
